pio_input_capture: RTL
======================

PIO_INPUT_CAPTURE -- requirements
Module: pio_input_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of input bits (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flops per bit (2..4).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16, stable cycles required; 0 disables debounce.
REQ-004 SHALL have parameter EDGE_MODE, default 0: 0 rising, 1 falling, 2 any edge.
REQ-005 SHALL have port clk  in  1  system clock, all logic on rising edge.
REQ-006 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port address  in  2  Avalon-MM word address.
REQ-008 SHALL have port chipselect  in  1  slave select, qualifies writes.
REQ-009 SHALL have port write_n  in  1  active-low write strobe.
REQ-010 SHALL have port writedata  in  WIDTH  write data.
REQ-011 SHALL have port in_port  in  WIDTH  asynchronous external inputs (kicker/sensor lines).
REQ-012 SHALL have port readdata  out  WIDTH  registered read data.
REQ-013 SHALL have port irq  out  1  level interrupt request.

Function
REQ-014 Register map SHALL be: 0 DATA (RO, debounced value), 1 IRQ_MASK (RW), 2 reserved (reads 0, writes ignored), 3 EDGE_CAPTURE (RO, write-1-to-clear).
REQ-015 readdata SHALL load the addressed register every clock regardless of chipselect; read latency 1 cycle, no wait states.
REQ-016 A write SHALL occur on a cycle with chipselect=1 and write_n=0; writedata bits above WIDTH ignored.
REQ-017 Each in_port bit SHALL pass through SYNC_STAGES flops to give sync value s.
REQ-018 Per bit, with D=DEBOUNCE_CYCLES>=1: if s equals stable, counter clears; else if counter equals D-1, stable<=s and counter clears; else counter increments.
REQ-019 With D=0, stable SHALL load s every cycle.
REQ-020 Total latency in_port change -> DATA change SHALL be SYNC_STAGES+max(D,1) cycles; a glitch shorter than D cycles at s SHALL NOT change DATA.
REQ-021 Counter width SHALL be clog2(D+1); counter SHALL never wrap.
REQ-022 Edge detect SHALL compare stable with its previous-cycle value; an edge matching EDGE_MODE SHALL set the EDGE_CAPTURE bit, sticky.
REQ-023 Writing 1 to an EDGE_CAPTURE bit SHALL clear it; writing 0 SHALL leave it.
REQ-024 New edge and clear on same bit same cycle: SHALL leave bit set (set wins).
REQ-025 irq SHALL equal OR over (EDGE_CAPTURE & IRQ_MASK), decoded from registers only, no in_port path.
REQ-026 Mask change SHALL affect irq the cycle after the write; captured bits persist while masked.

Reset
REQ-027 Reset SHALL clear readdata, sync flops, stable, previous stable, counters, IRQ_MASK, EDGE_CAPTURE; irq=0.
REQ-028 Input high through reset SHALL yield a rising edge SYNC_STAGES+max(D,1) cycles after release (defined, not suppressed).
REQ-029 Reset assertion mid-debounce SHALL abort the count; no partial state survives.

Structure
REQ-030 Shared package pio_pkg SHALL hold EDGE_MODE constants and register address constants (ADDR_DATA, ADDR_IRQ_MASK, ADDR_EDGE).
REQ-031 Per-bit synchronizer+debouncer SHALL be sub-module pio_debounce_bit, instantiated WIDTH times by generate.
REQ-032 Register file, edge logic, read mux and irq SHALL reside in pio_input_capture.

Verification (WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, EDGE_MODE=0 unless stated)
REQ-033 in_port 0x00->0x01 held -> DATA reads 0x01 exactly 6 cycles after change; EDGE_CAPTURE=0x01.
REQ-034 in_port bit2 pulsed high 3 cycles -> DATA stays 0x00, EDGE_CAPTURE stays 0x00.
REQ-035 Mask 0x01, edge on bit0 -> irq=1; write 0x01 to address 3 -> irq=0 next cycle; mask 0x00 with bit set -> irq=0.
REQ-036 Clear write to address 3 same cycle as new bit0 edge -> EDGE_CAPTURE bit0 remains 1.
REQ-037 EDGE_MODE=2, in_port 0x80 then 0x00 -> two captures; each clearable; EDGE_MODE=1 -> only high->low captures.
REQ-038 reset_n pulsed mid-debounce with in_port=0xFF -> all outputs 0 during reset; EDGE_CAPTURE=0xFF 6 cycles after release.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared constants for the PIO input-capture block:
// edge-mode selectors, register addresses and an edge-match helper.
package pio_pkg;

   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

   localparam logic [1:0] ADDR_DATA     = 2'd0;
   localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
   localparam logic [1:0] ADDR_RSVD     = 2'd2;
   localparam logic [1:0] ADDR_EDGE     = 2'd3;

   function automatic logic edge_hit(
      input int   mode,
      input logic cur,
      input logic prev
   );
      logic hit;
      hit = 1'b0;
      case (mode)
         EDGE_RISING:  hit = cur & ~prev;
         EDGE_FALLING: hit = ~cur & prev;
         EDGE_ANY:     hit = cur ^ prev;
         default:      hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input line: metastability synchronizer followed by a
// stability counter that only lets a level through once it has held.
module pio_debounce_bit #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din_i,
   output logic stable_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   stable_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_nodb
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               stable_q <= 1'b0;
            end else begin
               stable_q <= s;
            end
         end
      end else begin : g_db
         localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
         localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

         logic [CW-1:0] cnt_q;
         logic [CW-1:0] cnt_d;
         logic          stable_d;

         // Any disagreement must persist for DEBOUNCE_CYCLES samples in a row.
         always_comb begin
            cnt_d    = cnt_q;
            stable_d = stable_q;
            if (s == stable_q) begin
               cnt_d = '0;
            end else if (cnt_q == CMAX) begin
               stable_d = s;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt_q    <= '0;
               stable_q <= 1'b0;
            end else begin
               cnt_q    <= cnt_d;
               stable_q <= stable_d;
            end
         end
      end
   endgenerate

   assign stable_o = stable_q;

endmodule

// File: rtl/pio_input_capture.sv
// Avalon-MM PIO input port with per-bit debounce, sticky edge
// capture (write-1-to-clear), interrupt mask and level irq.
module pio_input_capture
   import pio_pkg::*;
#(
   parameter int WIDTH           = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int EDGE_MODE       = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [WIDTH-1:0] writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] readdata,
   output logic             irq
);

   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] hit;
   logic [WIDTH-1:0] mask_q;
   logic [WIDTH-1:0] mask_d;
   logic [WIDTH-1:0] edge_q;
   logic [WIDTH-1:0] edge_d;
   logic [WIDTH-1:0] rd_q;
   logic [WIDTH-1:0] rd_d;
   logic             wr;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         pio_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_db (
            .clk      (clk),
            .reset_n  (reset_n),
            .din_i    (in_port[gi]),
            .stable_o (stable[gi])
         );
      end
   endgenerate

   assign wr = chipselect & ~write_n;

   // Clear first, then OR in new edges so a fresh edge survives its clear.
   always_comb begin
      hit    = '0;
      mask_d = mask_q;
      edge_d = edge_q;
      for (int i = 0; i < WIDTH; i++) begin
         hit[i] = edge_hit(EDGE_MODE, stable[i], prev_q[i]);
      end
      if (wr && address == ADDR_IRQ_MASK) begin
         mask_d = writedata;
      end
      if (wr && address == ADDR_EDGE) begin
         edge_d = edge_q & ~writedata;
      end
      edge_d = edge_d | hit;
   end

   always_comb begin
      rd_d = '0;
      case (address)
         ADDR_DATA:     rd_d = stable;
         ADDR_IRQ_MASK: rd_d = mask_q;
         ADDR_RSVD:     rd_d = '0;
         ADDR_EDGE:     rd_d = edge_q;
         default:       rd_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q <= '0;
         mask_q <= '0;
         edge_q <= '0;
         rd_q   <= '0;
      end else begin
         prev_q <= stable;
         mask_q <= mask_d;
         edge_q <= edge_d;
         rd_q   <= rd_d;
      end
   end

   assign readdata = rd_q;
   assign irq      = |(edge_q & mask_q);

endmodule
